div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the ALU divide path: one restoring-division step per clock.
//  Replaces the unrolled combinational divider on the DIV opcode.
//  The control unit pulses start; the block iterates, then presents quotient (to ZLow)
//  and remainder (to ZHigh) with a one-cycle done pulse.
//  Stalls the control FSM via busy.
// PARAMETERS
//  WIDTH   32  operand/result width; iteration count = WIDTH
// PORTS
//  clk        in   1      system clock, rising edge
//  clr        in   1      asynchronous reset, active-high
//  start      in   1      request; sampled only in IDLE
//  dividend   in   WIDTH  numerator, captured when start accepted
//  divisor    in   WIDTH  denominator, captured when start accepted
//  busy       out  1      high from cycle after accept until done cycle, inclusive
//  done       out  1      one-cycle pulse; results valid from this cycle
//  quotient   out  WIDTH  -> ZLow
//  remainder  out  WIDTH  -> ZHigh
//  div_zero   out  1      divisor was zero for the last accepted op
// BEHAVIOUR
//  - One clock. clr is async, active-high: state=IDLE and all outputs/internal regs = 0.
//    Applies at any time, incl. mid-ITER; the op is abandoned and no done is issued.
//  - States: IDLE -> (start) -> [SGN] -> ITER x WIDTH -> [FIX] -> DONE -> IDLE.
//    SGN/FIX exist only with DIV_SIGNED_EN.
//  - IDLE: start=1 captures operands; R<=0, Q<=dividend (magnitudes if signed), cnt<=0.
//    If divisor==0, go straight to DONE.
//  - ITER, each cycle:
//    {R,Q} <= {R,Q}<<1; T = R_shifted - divisor (WIDTH+1 bits, zero-extended).
//    T[WIDTH]==0: R<=T[WIDTH-1:0], Q[0]<=1. Else R unchanged, Q[0]<=0.
//    cnt increments; leave ITER after cnt==WIDTH-1.
//  - DONE: quotient<=Q, remainder<=R, done=1 for exactly one cycle, busy=1.
//    Next state is IDLE unconditionally.
//  - Latency (unsigned), start accepted at edge 0: done high during cycle WIDTH+1 (33).
//    Divide-by-zero: done in cycle 1.
//  - Divide-by-zero: quotient={WIDTH{1}}, remainder=dividend, div_zero=1.
//    div_zero is cleared at the next accepted start.
//  - start while busy is ignored, not queued. start in the DONE cycle is ignored.
//    Back-to-back ops need start in the first IDLE cycle.
//  - quotient/remainder/div_zero hold their last values until the next DONE or clr.
//    They do not change during ITER.
//  - Operand inputs may change freely after the accept edge.
// CONFIGURATION
//  DIV_SIGNED_EN defined:
//   - Operands are two's complement. SGN state (1 cycle) takes magnitudes and records
//     sq = sign(dividend)^sign(divisor) and sr = sign(dividend).
//   - FIX state (1 cycle) negates Q if sq and negates R if sr, so quotient truncates
//     toward zero. Latency becomes WIDTH+3 (35).
//   - Divide-by-zero bypasses SGN/FIX with the same outputs as unsigned.
//  DIV_SIGNED_EN undefined: pure unsigned; no SGN/FIX states or sign logic.
// TESTING
//  1. 100/7 unsigned, start 1 cycle -> busy next cycle; done in cycle 33;
//     quotient=14, remainder=2, div_zero=0.
//  2. 0xFFFFFFFF/1 then 5/10 back-to-back (second start in first IDLE cycle) ->
//     q=0xFFFFFFFF r=0; then q=0 r=5.
//  3. 1234/0 -> done cycle 1, quotient=0xFFFFFFFF, remainder=1234, div_zero=1;
//     next op 8/2 clears div_zero.
//  4. start pulsed at cycles 5 and 20 of 100/7 with other operands -> ignored;
//     single done, q=14 r=2.
//  5. clr asserted mid-ITER (cycle 10) -> outputs 0 immediately, no done;
//     a fresh 9/4 afterwards gives q=2 r=1.
//  6. 0xFFFFFFF9/2: without DIV_SIGNED_EN -> q=0x7FFFFFFC r=1, done cycle 33.
//     With DIV_SIGNED_EN (-7/2) -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1), done cycle 35.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - sequential restoring divider, one quotient bit per clock.
// Optional two's-complement operands with `define DIV_SIGNED_EN (adds SGN and FIX states).
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_DONE = 3'd4;
`ifdef DIV_SIGNED_EN
    localparam logic [2:0] S_SGN  = 3'd1;
    localparam logic [2:0] S_FIX  = 3'd3;
`endif

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] work_r_q, work_r_d;
    logic [WIDTH-1:0] work_q_q, work_q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH:0]   trial;
`ifdef DIV_SIGNED_EN
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_r_d   = work_r_q;
        work_q_d   = work_q_q;
        dvs_d      = dvs_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        div_zero_d = div_zero_q;
        trial      = '0;
`ifdef DIV_SIGNED_EN
        sq_d       = sq_q;
        sr_d       = sr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_r_d   = '0;
                    work_q_d   = dividend;
                    dvs_d      = divisor;
                    cnt_d      = '0;
                    div_zero_d = (divisor == '0);
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        state_d = S_DONE;
                    end else begin
`ifdef DIV_SIGNED_EN
                        state_d = S_SGN;
`else
                        state_d = S_ITER;
`endif
                    end
                end
            end
`ifdef DIV_SIGNED_EN
            S_SGN: begin
                sq_d     = work_q_q[WIDTH-1] ^ dvs_q[WIDTH-1];
                sr_d     = work_q_q[WIDTH-1];
                work_q_d = work_q_q[WIDTH-1] ? -work_q_q : work_q_q;
                dvs_d    = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
                state_d  = S_ITER;
            end
            S_FIX: begin
                quot_d  = sq_q ? -work_q_q : work_q_q;
                rem_d   = sr_q ? -work_r_q : work_r_q;
                state_d = S_DONE;
            end
`endif
            S_ITER: begin
                // The bit shifted out of R takes part in the compare, so divisors above 2^(WIDTH-1) work.
                trial    = {work_r_q, work_q_q[WIDTH-1]} - {1'b0, dvs_q};
                work_q_d = {work_q_q[WIDTH-2:0], ~trial[WIDTH]};
                work_r_d = trial[WIDTH] ? {work_r_q[WIDTH-2:0], work_q_q[WIDTH-1]}
                                        : trial[WIDTH-1:0];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef DIV_SIGNED_EN
                    state_d = S_FIX;
`else
                    quot_d  = work_q_d;
                    rem_d   = work_r_d;
                    state_d = S_DONE;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            work_r_q   <= '0;
            work_q_q   <= '0;
            dvs_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            sq_q       <= 1'b0;
            sr_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_r_q   <= work_r_d;
            work_q_q   <= work_q_d;
            dvs_q      <= dvs_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_zero_q <= div_zero_d;
`ifdef DIV_SIGNED_EN
            sq_q       <= sq_d;
            sr_q       <= sr_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - table-driven, scoreboard-checked bench for div_seq_ctrl.
module tb_div_seq_ctrl;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

`ifdef DIV_SIGNED_EN
    localparam int LAT = 35;
`else
    localparam int LAT = 33;
`endif
    localparam int NVEC = 9;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_q = '0;
    exp_t        sb[$];
    vec_t        vecs[NVEC];

    div_seq_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Called in an IDLE cycle; returns in the first IDLE cycle after done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                          input logic [31:0] r, input logic dz, input bit poke);
        exp_t e;
        int   n;
        e.q   = q;
        e.r   = r;
        e.dz  = dz;
        e.lat = dz ? 1 : LAT;
        sb.push_back(e);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        n        = 1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check("busy_after_accept", 32'(busy), 32'd1);
        while (!done && n < LAT + 5) begin
            if (n == 3) check("hold_during_iter", quotient, last_q);
            if (poke && (n == 5 || n == 20)) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = $urandom_range(1, 9);
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        e = sb.pop_front();
        if (!done) begin
            check("done_timeout", 32'(done), 32'd1);
            return;
        end
        check("latency", 32'(n), 32'(e.lat));
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_zero", 32'(div_zero), 32'(e.dz));
        check("busy_in_done", 32'(busy), 32'd1);
        last_q = e.q;
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int n_done;
        vecs[0] = '{32'd100,        32'd7,        32'd14,        32'd2,        1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0};
        vecs[2] = '{32'd5,          32'd10,       32'd0,         32'd5,        1'b0};
        vecs[3] = '{32'd1234,       32'd0,        32'hFFFF_FFFF, 32'd1234,     1'b1};
        vecs[4] = '{32'd8,          32'd2,        32'd4,         32'd0,        1'b0};
        vecs[5] = '{32'h7FFF_FFFF,  32'h1_0000,   32'h7FFF,      32'hFFFF,     1'b0};
`ifdef DIV_SIGNED_EN
        vecs[6] = '{32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'd0,        32'hFFFF_FFFF, 1'b0};
        vecs[8] = '{32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0};
`else
        vecs[6] = '{32'hFFFF_FFF9,  32'd2,        32'h7FFF_FFFC, 32'd1,        1'b0};
        vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'd1,        32'd1,        1'b0};
        vecs[8] = '{32'd7,          32'hFFFF_FFFE, 32'd0,        32'd7,        1'b0};
`endif

        clr      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        clr = 1'b0;
        tick();

        // Each op starts in the first IDLE cycle of the previous one: back-to-back.
        for (int i = 0; i < NVEC; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0);

        tick();
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);

        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        clr = 1'b1;
        #1;
        check("clr_quotient", quotient, 32'd0);
        check("clr_remainder", remainder, 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        tick();
        tick();
        clr    = 1'b0;
        n_done = 0;
        repeat (40) begin
            tick();
            if (done) n_done++;
        end
        check("no_done_after_clr", 32'(n_done), 32'd0);
        last_q = '0;
        run_op(32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
